// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multi-cycle RV32I core.
// Sequences the shared ALU, memory and register file for lw, sw, R/I-ALU,
// beq/bne/blt/bge, jal, jalr and lui.
// Optional feature macro: MEM_HANDSHAKE_EN adds a mem_ready input that
// stalls FETCH, MEMREAD and MEMWRITE until memory responds.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MEM_HANDSHAKE_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, HALT
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t state, state_nx;
  state_t ill_st;
  logic   rdy;
  logic   alu_ok, br_ok, taken;
  logic   pcw_raw, mw_raw, irw_raw, rw_raw;

`ifdef MEM_HANDSHAKE_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // Unknown encodings either park the core or are skipped as a NOP.
  assign ill_st = HALT_ON_ILLEGAL ? HALT : FETCH;

  // funct3 legality and branch condition from the ALU flags of rs1-rs2.
  always_comb begin
    alu_ok = 1'b1;
    br_ok  = 1'b1;
    taken  = 1'b0;
    case (funct3)
      3'b001, 3'b011, 3'b101: alu_ok = 1'b0;
      default:                alu_ok = 1'b1;
    endcase
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      3'b101:  taken = ~neg;
      default: br_ok = 1'b0;
    endcase
  end

  // Next-state sequencing; memory states wait on rdy.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:    if (rdy) state_nx = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_R:         state_nx = EXECR;
          OP_I:         state_nx = EXECI;
          OP_BR:        state_nx = BRANCH;
          OP_JAL:       state_nx = JAL;
          OP_JALR:      state_nx = JALR1;
          OP_LUI:       state_nx = LUI;
          default:      state_nx = ill_st;
        endcase
      end
      MEMADR:   state_nx = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (rdy) state_nx = MEMWB;
      MEMWB:    state_nx = FETCH;
      MEMWRITE: if (rdy) state_nx = FETCH;
      EXECR,
      EXECI:    state_nx = alu_ok ? ALUWB : ill_st;
      ALUWB:    state_nx = FETCH;
      BRANCH:   state_nx = br_ok ? FETCH : ill_st;
      JAL:      state_nx = ALUWB;
      JALR1:    state_nx = JALR2;
      JALR2:    state_nx = ALUWB;
      LUI:      state_nx = FETCH;
      HALT:     state_nx = HALT;
      default:  state_nx = FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Moore decode of datapath controls; enables gated by rst and rdy.
  always_comb begin
    pcw_raw     = 1'b0;
    mw_raw      = 1'b0;
    irw_raw     = 1'b0;
    rw_raw      = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (state)
      FETCH: begin
        irw_raw    = rdy;
        pcw_raw    = rdy;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        rw_raw     = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw_raw  = rdy;
      end
      EXECR, EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = (state == EXECI) ? 2'b01 : 2'b00;
        case (funct3)
          3'b000:  alu_control = (state == EXECR && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      ALUWB:    rw_raw = 1'b1;
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pcw_raw     = taken;
      end
      JAL, JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw_raw   = 1'b1;
      end
      JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      LUI: begin
        result_src = 2'b11;
        rw_raw     = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write  = pcw_raw & ~rst;
  assign mem_write = mw_raw  & ~rst;
  assign ir_write  = irw_raw & ~rst;
  assign reg_write = rw_raw  & ~rst;
  assign illegal   = (state == HALT) & ~rst;

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

endmodule
